// File: rtl/grf_wport_arbiter.sv
// grf_wport_arbiter
//   Shares the single GRF write port between two sources:
//   - pipeline writeback (WB), which normally has priority;
//   - the multicycle mul/div unit (MD), whose results wait in a small FIFO.
//   If the FIFO head loses to WB for MAX_WAIT cycles in a row, WB is stalled
//   for one cycle so the head can drain. Decode gets a combinational hazard
//   flag for any register that still has a pending write.
//
// Ports
//   Clk                 clock, all state on posedge
//   Reset               synchronous active-low reset
//   WB_Valid/RD/Data    writeback request (held by the pipeline while WB_Stall)
//   WB_Stall            1 = WB request not consumed this cycle
//   MD_Valid/RD/Data    mul/div result, transferred when MD_Valid & MD_Ready
//   MD_Ready            1 = FIFO can accept an MD result
//   RS1, RS2            decode read addresses
//   Hazard1, Hazard2    pending write to RS1 / RS2 (never for x0)
//   RegWrite, RD, WData registered GRF write port
module grf_wport_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8,
  parameter int DW       = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          WB_Valid,
  input  logic [4:0]    WB_RD,
  input  logic [DW-1:0] WB_Data,
  output logic          WB_Stall,
  input  logic          MD_Valid,
  input  logic [4:0]    MD_RD,
  input  logic [DW-1:0] MD_Data,
  output logic          MD_Ready,
  input  logic [4:0]    RS1,
  input  logic [4:0]    RS2,
  output logic          Hazard1,
  output logic          Hazard2,
  output logic          RegWrite,
  output logic [4:0]    RD,
  output logic [DW-1:0] WData
);

  localparam int PW = $clog2(DEPTH);
  localparam int AW = $clog2(MAX_WAIT + 1);
  localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [AW-1:0] AGE_MAX  = MAX_WAIT[AW-1:0];
  localparam logic [AW-1:0] AGE_ONE  = 1;

  // FIFO storage; valid_q is only ever set on occupied slots, so it doubles
  // as the "pending write" mask used by the hazard check.
  logic [DEPTH-1:0] valid_q;
  logic [4:0]       rd_q   [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, rdPtr_q;
  logic [PW:0]      count_q;
  logic [AW-1:0]    age_q, age_d;

  logic          regWrite_q, regWrite_d;
  logic [4:0]    rdOut_q, rdOut_d;
  logic [DW-1:0] wData_q, wData_d;

  logic empty, full, stall, wbGrant, pop, push, pushValid;
  logic hit1, hit2;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

  // Stall only ever happens with a non-empty FIFO (age is 0 when empty),
  // so the stall cycle always has a head to pop.
  assign stall    = Reset && (age_q == AGE_MAX);
  assign WB_Stall = stall;
  assign MD_Ready = Reset && !full;

  assign wbGrant   = !stall && WB_Valid && (WB_RD != 5'd0);
  assign pop       = !empty && !wbGrant;
  assign push      = MD_Valid && MD_Ready && (MD_RD != 5'd0);
  // A same-cycle WB to the same register supersedes the incoming MD result.
  assign pushValid = !(wbGrant && (MD_RD == WB_RD));

  always_comb begin
    regWrite_d = 1'b0;
    rdOut_d    = 5'd0;
    wData_d    = '0;
    if (wbGrant) begin
      regWrite_d = 1'b1;
      rdOut_d    = WB_RD;
      wData_d    = WB_Data;
    end else if (pop && valid_q[rdPtr_q]) begin
      regWrite_d = 1'b1;
      rdOut_d    = rd_q[rdPtr_q];
      wData_d    = data_q[rdPtr_q];
    end
  end

  always_comb begin
    age_d = age_q;
    if (empty || pop) begin
      age_d = '0;
    end else if (age_q != AGE_MAX) begin
      age_d = age_q + AGE_ONE;
    end
  end

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (rd_q[i] == RS1)) hit1 = 1'b1;
      if (valid_q[i] && (rd_q[i] == RS2)) hit2 = 1'b1;
    end
  end

  assign Hazard1 = (RS1 != 5'd0) && (hit1 || (regWrite_q && (rdOut_q == RS1)));
  assign Hazard2 = (RS2 != 5'd0) && (hit2 || (regWrite_q && (rdOut_q == RS2)));

  // Later assignments to valid_q win: WB supersede, then pop clear, then push.
  // Push and pop never target the same slot (push needs !full, pop !empty).
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      valid_q    <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      age_q      <= '0;
      regWrite_q <= 1'b0;
      rdOut_q    <= 5'd0;
      wData_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wbGrant && (rd_q[i] == WB_RD)) valid_q[i] <= 1'b0;
      end
      if (pop) begin
        valid_q[rdPtr_q] <= 1'b0;
        rdPtr_q          <= rdPtr_q + PTR_ONE;
      end
      if (push) begin
        valid_q[wrPtr_q] <= pushValid;
        rd_q[wrPtr_q]    <= MD_RD;
        data_q[wrPtr_q]  <= MD_Data;
        wrPtr_q          <= wrPtr_q + PTR_ONE;
      end
      if (push && !pop)      count_q <= count_q + CNT_ONE;
      else if (pop && !push) count_q <= count_q - CNT_ONE;
      age_q      <= age_d;
      regWrite_q <= regWrite_d;
      rdOut_q    <= rdOut_d;
      wData_q    <= wData_d;
    end
  end

  assign RegWrite = regWrite_q;
  assign RD       = rdOut_q;
  assign WData    = wData_q;

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// tb_grf_wport_arbiter
//   Drives directed scenarios followed by random traffic into
//   grf_wport_arbiter. A queue-based reference model predicts the write port
//   output for the next cycle and pushes it onto expQ; a monitor process pops
//   one expectation after every posedge and compares it with RegWrite/RD/WData.
//   Stall, ready and hazard flags are checked against the model before each
//   edge.
module tb_grf_wport_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;
  localparam int DW       = 32;

  logic          Clk, Reset;
  logic          WB_Valid, WB_Stall, MD_Valid, MD_Ready;
  logic [4:0]    WB_RD, MD_RD, RS1, RS2, RD;
  logic [DW-1:0] WB_Data, MD_Data, WData;
  logic          Hazard1, Hazard2, RegWrite;

  grf_wport_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .DW(DW)) dut (
    .Clk(Clk), .Reset(Reset),
    .WB_Valid(WB_Valid), .WB_RD(WB_RD), .WB_Data(WB_Data), .WB_Stall(WB_Stall),
    .MD_Valid(MD_Valid), .MD_RD(MD_RD), .MD_Data(MD_Data), .MD_Ready(MD_Ready),
    .RS1(RS1), .RS2(RS2), .Hazard1(Hazard1), .Hazard2(Hazard2),
    .RegWrite(RegWrite), .RD(RD), .WData(WData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct { bit v; bit [4:0] rd; bit [31:0] d; } entry_t;
  typedef struct { bit w; bit [4:0] rd; bit [31:0] d; } exp_t;

  // Reference model state: pending MD results in arrival order, the number
  // of consecutive cycles the head has lost, and the write last presented.
  entry_t mq[$];
  exp_t   expQ[$];
  int     age = 0;
  bit     lastW = 0;
  bit [4:0] lastRd = 0;

  int compared = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit modelHazard(input bit [4:0] rs);
    if (rs == 0) return 0;
    if (lastW && lastRd == rs) return 1;
    foreach (mq[i]) if (mq[i].v && mq[i].rd == rs) return 1;
    return 0;
  endfunction

  // One clock cycle: drive inputs after negedge, check flags, then advance
  // the model and queue the expected write port for after the next posedge.
  task automatic applyStimulus(input bit rstN, input bit wbV, input bit [4:0] wbRd,
                               input bit [31:0] wbD, input bit mdV, input bit [4:0] mdRd,
                               input bit [31:0] mdD, input bit [4:0] rs1, input bit [4:0] rs2,
                               output bit wbTaken, output bit mdTaken);
    bit expStall, expReady, grant;
    exp_t o;
    entry_t e;
    int sizeBefore;
    @(negedge Clk);
    Reset = rstN; WB_Valid = wbV; WB_RD = wbRd; WB_Data = wbD;
    MD_Valid = mdV; MD_RD = mdRd; MD_Data = mdD; RS1 = rs1; RS2 = rs2;
    #1;
    expStall = rstN && (age == MAX_WAIT);
    expReady = rstN && (mq.size() < DEPTH);
    checkOutput("WB_Stall", {31'd0, WB_Stall}, {31'd0, expStall});
    checkOutput("MD_Ready", {31'd0, MD_Ready}, {31'd0, expReady});
    checkOutput("Hazard1", {31'd0, Hazard1}, {31'd0, modelHazard(rs1)});
    checkOutput("Hazard2", {31'd0, Hazard2}, {31'd0, modelHazard(rs2)});
    o = '{w: 0, rd: 0, d: 0};
    wbTaken = !expStall;
    mdTaken = mdV && expReady;
    if (!rstN) begin
      mq.delete();
      age = 0;
    end else begin
      sizeBefore = mq.size();
      grant = !expStall && wbV && wbRd != 0;
      if (grant) begin
        o = '{w: 1, rd: wbRd, d: wbD};
        foreach (mq[i]) if (mq[i].rd == wbRd) mq[i].v = 0;
      end else if (sizeBefore > 0) begin
        e = mq.pop_front();
        if (e.v) o = '{w: 1, rd: e.rd, d: e.d};
      end
      if (sizeBefore == 0 || !grant) age = 0;
      else if (age < MAX_WAIT) age++;
      if (mdTaken && mdRd != 0)
        mq.push_back('{v: !(grant && mdRd == wbRd), rd: mdRd, d: mdD});
    end
    expQ.push_back(o);
    lastW = o.w;
    lastRd = o.rd;
  endtask

  // Monitor: one expectation per cycle, compared just after the posedge.
  initial begin
    exp_t x;
    forever begin
      @(posedge Clk);
      #1;
      if (expQ.size() > 0) begin
        x = expQ.pop_front();
        checkOutput("RegWrite", {31'd0, RegWrite}, {31'd0, x.w});
        if (x.w) begin
          checkOutput("RD", {27'd0, RD}, {27'd0, x.rd});
          checkOutput("WData", WData, x.d);
        end
      end
    end
  end

  initial begin
    bit wt, mt;
    bit wv, mv, rst;
    bit [4:0] wr, mr, r1, r2;
    bit [31:0] wd, md;
    int idx;
    Reset = 0; WB_Valid = 0; WB_RD = 0; WB_Data = 0;
    MD_Valid = 0; MD_RD = 0; MD_Data = 0; RS1 = 0; RS2 = 0;

    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, wt, mt);

    // Plain WB write.
    applyStimulus(1, 1, 5, 32'hA5A5A5A5, 0, 0, 0, 5, 0, wt, mt);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 5, 0, wt, mt);

    // Single MD result through an idle port; hazard tracked on RS1=7.
    applyStimulus(1, 0, 0, 0, 1, 7, 32'd1234, 7, 0, wt, mt);
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, 7, 0, wt, mt);

    // Continuous WB to x3 starves one MD result until the stall.
    applyStimulus(1, 1, 3, 32'h33, 1, 9, 32'h99, 9, 3, wt, mt);
    repeat (12) applyStimulus(1, 1, 3, 32'h33, 0, 0, 0, 9, 3, wt, mt);

    // DEPTH+1 MD results against busy WB; the fifth waits for a slot.
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1, 1, 3, 32'h1000 + c, idx < 5, 5'(11 + idx), 32'h500 + idx,
                    11, 15, wt, mt);
      if (mt) idx++;
    end
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, wt, mt);

    // WB to x4 supersedes a queued MD write to x4; MD to x0 is dropped.
    applyStimulus(1, 1, 3, 32'h3, 1, 4, 32'hDEAD, 4, 0, wt, mt);
    applyStimulus(1, 1, 4, 32'hBEEF, 0, 0, 0, 4, 0, wt, mt);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 4, 0, wt, mt);
    applyStimulus(1, 0, 0, 0, 1, 0, 32'h77, 0, 0, wt, mt);
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, wt, mt);

    // Reset with three results queued.
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1, 3, 32'h3, 1, 5'(20 + i), 32'h20 + i, 20, 21, wt, mt);
    applyStimulus(0, 1, 3, 32'h3, 0, 0, 0, 20, 21, wt, mt);
    repeat (4) applyStimulus(1, 0, 0, 0, 0, 0, 0, 20, 21, wt, mt);

    // Random traffic honouring both handshakes.
    wt = 1; mt = 0; mv = 0; wv = 0; wr = 0; wd = 0; mr = 0; md = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) != 0);
      if (wt) begin
        wv = ($urandom_range(0, 99) < 85);
        wr = 5'($urandom_range(0, 7));
        wd = $urandom;
      end
      if (!(mv && !mt)) begin
        mv = ($urandom_range(0, 1) == 1);
        mr = 5'($urandom_range(0, 7));
        md = $urandom;
      end
      r1 = 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      applyStimulus(rst, wv, wr, wd, mv, mr, md, r1, r2, wt, mt);
      if (!rst) begin
        wt = 1;
        mv = 0;
      end
    end

    repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, wt, mt);
    @(posedge Clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
